// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - NUM_IRQ-channel external interrupt controller feeding the 6-bit CP0 int input
// Optional build macro: INT_CTRL_CLAIM_EN (reading a valid ID claims the reported edge-mode channel).
module int_ctrl #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               timer_int_i,
    input  logic               ce_i,
    input  logic               we_i,
    input  logic [4:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic [5:0]         int_o
);

    localparam logic [2:0] REG_PENDING  = 3'd0;
    localparam logic [2:0] REG_MASK     = 3'd1;
    localparam logic [2:0] REG_MODE     = 3'd2;
    localparam logic [2:0] REG_POLARITY = 3'd3;
    localparam logic [2:0] REG_ID       = 3'd4;

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] hist;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] mode;
    logic [NUM_IRQ-1:0] polarity;

    logic [NUM_IRQ-1:0] s;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] wdata_n;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] claim_clr;
    logic [NUM_IRQ-1:0] pending_next;
    logic [2:0]         reg_sel;
    logic               wr_en;
    logic               rd_en;
    logic               id_valid;
    logic [4:0]         id_idx;
    logic [31:0]        rd_val;
    logic [5:0]         int_next;
    logic               unused_bits;

    function automatic logic [31:0] zext(input logic [NUM_IRQ-1:0] v);
        logic [31:0] r;
        r = '0;
        r[NUM_IRQ-1:0] = v;
        return r;
    endfunction

    assign reg_sel     = addr_i[4:2];
    assign wr_en       = ce_i & we_i;
    assign rd_en       = ce_i & ~we_i;
    assign wdata_n     = wdata_i[NUM_IRQ-1:0];
    assign unused_bits = ^{addr_i[1:0], wdata_i};

    assign s      = sync_q[SYNC_STAGES-1] ^ polarity;
    assign rise   = s & ~hist;
    assign active = pending & mask;
    assign w1c    = (wr_en && reg_sel == REG_PENDING) ? wdata_n : '0;

    // Scan downward so the lowest-numbered active channel is the one left standing.
    always_comb begin
        id_valid = 1'b0;
        id_idx   = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                id_valid = 1'b1;
                id_idx   = 5'(i);
            end
        end
    end

`ifdef INT_CTRL_CLAIM_EN
    always_comb begin
        claim_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            claim_clr[i] = rd_en && (reg_sel == REG_ID) && id_valid && mode[i] && (id_idx == 5'(i));
        end
    end
`else
    assign claim_clr = '0;
`endif

    // Edge channels: a fresh edge beats any clear; level channels simply track s.
    assign pending_next = (mode & (rise | (pending & ~(w1c | claim_clr)))) | (~mode & s);

    always_comb begin
        int_next = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            int_next[i % 5] = int_next[i % 5] | active[i];
        end
        int_next[5] = timer_int_i;
    end

    always_comb begin
        rd_val = '0;
        case (reg_sel)
            REG_PENDING:  rd_val = zext(pending);
            REG_MASK:     rd_val = zext(mask);
            REG_MODE:     rd_val = zext(mode);
            REG_POLARITY: rd_val = zext(polarity);
            REG_ID:       rd_val = id_valid ? {1'b1, 26'd0, id_idx} : 32'd0;
            default:      rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= '0;
            end
        end else begin
            sync_q[0] <= irq_i;
            for (int j = 1; j < SYNC_STAGES; j++) begin
                sync_q[j] <= sync_q[j-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist     <= '0;
            pending  <= '0;
            mask     <= '0;
            mode     <= '0;
            polarity <= '0;
            int_o    <= '0;
            rdata_o  <= '0;
        end else begin
            hist    <= s;
            pending <= pending_next;
            int_o   <= int_next;
            if (wr_en) begin
                case (reg_sel)
                    REG_MASK:     mask     <= wdata_n;
                    REG_MODE:     mode     <= wdata_n;
                    REG_POLARITY: polarity <= wdata_n;
                    default:      ;
                endcase
            end
            if (rd_en) begin
                rdata_o <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - self-checking bench for int_ctrl: vector table, scoreboard reads, corner sequences
module tb_int_ctrl;

    localparam int NUM_IRQ = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_IRQ-1:0] irq_i;
    logic               timer_int_i;
    logic               ce_i;
    logic               we_i;
    logic [4:0]         addr_i;
    logic [31:0]        wdata_i;
    logic [31:0]        rdata_o;
    logic [5:0]         int_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    int_ctrl #(.NUM_IRQ(NUM_IRQ), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .irq_i(irq_i), .timer_int_i(timer_int_i),
        .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rdata_o(rdata_o), .int_o(int_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        ce_i = 1'b1; we_i = 1'b1; addr_i = addr; wdata_i = data;
        cycle();
        ce_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] addr, input logic [31:0] exp, input string name);
        sb_t e;
        e.exp = exp; e.name = name;
        ce_i = 1'b1; we_i = 1'b0; addr_i = addr;
        sb.push_back(e);
        cycle();
        ce_i = 1'b0;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk(e.name, rdata_o, e.exp);
        end
    endtask

    function automatic void add_vec(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] exp, input string name);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic pulse(input logic [NUM_IRQ-1:0] bits);
        irq_i = irq_i | bits;
        cycle();
        irq_i = irq_i & ~bits;
    endtask

    initial begin
        rst = 1'b1; irq_i = '0; timer_int_i = 1'b0;
        ce_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        wait_cycles(3);
        rst = 1'b0;
        chk("reset_int_o", 32'(int_o), 32'd0);
        chk("reset_rdata", rdata_o, 32'd0);

        add_vec(1'b0, 5'd0,  32'h0, 32'h0, "rst_pending");
        add_vec(1'b0, 5'd4,  32'h0, 32'h0, "rst_mask");
        add_vec(1'b0, 5'd8,  32'h0, 32'h0, "rst_mode");
        add_vec(1'b0, 5'd12, 32'h0, 32'h0, "rst_polarity");
        add_vec(1'b0, 5'd16, 32'h0, 32'h0, "rst_id");
        add_vec(1'b1, 5'd4,  32'hFFFF_FFFF, 32'h0, "");
        add_vec(1'b0, 5'd5,  32'h0, 32'h0000_00FF, "mask_upper_bits_dropped");
        add_vec(1'b1, 5'd8,  32'h0000_01A5, 32'h0, "");
        add_vec(1'b0, 5'd11, 32'h0, 32'h0000_00A5, "mode_readback");
        add_vec(1'b1, 5'd20, 32'h1234_5678, 32'h0, "");
        add_vec(1'b0, 5'd20, 32'h0, 32'h0, "reg5_reads_zero");
        add_vec(1'b0, 5'd28, 32'h0, 32'h0, "reg7_reads_zero");
        add_vec(1'b1, 5'd8,  32'h0000_0001, 32'h0, "");
        add_vec(1'b0, 5'd4,  32'h0, 32'h0000_00FF, "mask_kept");
        for (int v = 0; v < vecs.size(); v++) begin
            if (vecs[v].we) do_write(vecs[v].addr, vecs[v].wdata);
            else            do_read(vecs[v].addr, vecs[v].exp, vecs[v].name);
        end

        // Edge channel 0: exact 4-clock latency, then W1C.
        pulse(8'h01);
        wait_cycles(2);
        chk("edge0_int_early", 32'(int_o[0]), 32'd0);
        cycle();
        chk("edge0_int_latency4", 32'(int_o[0]), 32'd1);
        do_read(5'd0, 32'h01, "edge0_pending");
        do_write(5'd0, 32'h01);
        chk("edge0_int_after_w1c_edge", 32'(int_o[0]), 32'd1);
        cycle();
        chk("edge0_int_cleared", 32'(int_o[0]), 32'd0);

        // Level channel 6 maps onto int_o[1].
        irq_i[6] = 1'b1;
        wait_cycles(4);
        chk("level6_int", 32'(int_o), 32'h02);
        do_write(5'd0, 32'h40);
        do_read(5'd0, 32'h40, "level6_w1c_ignored");
        irq_i[6] = 1'b0;
        wait_cycles(3);
        chk("level6_int_still", 32'(int_o[1]), 32'd1);
        cycle();
        chk("level6_int_dropped", 32'(int_o[1]), 32'd0);

        // Priority ID with channels 3 and 5.
        do_write(5'd8, 32'h29);
        pulse(8'h28);
        wait_cycles(4);
        chk("ch3_ch5_int", 32'(int_o), 32'h09);
        do_read(5'd16, 32'h8000_0003, "id_ch3");
        do_write(5'd4, 32'hF7);
        do_read(5'd16, 32'h8000_0005, "id_ch5");
        do_write(5'd4, 32'h00);
        do_read(5'd16, 32'h0, "id_none");
        chk("mask0_int", 32'(int_o), 32'h0);
        do_write(5'd0, 32'hFF);
        do_write(5'd4, 32'hFF);

        // Active-low edge channel 2.
        irq_i[2] = 1'b1;
        wait_cycles(4);
        do_write(5'd12, 32'h04);
        do_write(5'd8, 32'h2D);
        wait_cycles(3);
        do_write(5'd0, 32'hFF);
        do_read(5'd0, 32'h0, "pol2_idle_clear");
        irq_i[2] = 1'b0;
        wait_cycles(4);
        do_read(5'd0, 32'h04, "pol2_falling_edge");
        do_write(5'd0, 32'h04);
        do_read(5'd0, 32'h0, "pol2_w1c");
        irq_i[2] = 1'b1;
        wait_cycles(4);
        irq_i[2] = 1'b0;
        wait_cycles(2);
        do_write(5'd0, 32'h04);
        do_read(5'd0, 32'h04, "pol2_edge_beats_w1c");

        // Claim behaviour on edge channel 1.
        do_write(5'd0, 32'hFF);
        do_write(5'd4, 32'h02);
        do_write(5'd8, 32'h2F);
        pulse(8'h02);
        wait_cycles(4);
        do_read(5'd16, 32'h8000_0001, "id_ch1_first");
`ifdef INT_CTRL_CLAIM_EN
        do_read(5'd16, 32'h0, "id_ch1_claimed");
        do_read(5'd0, 32'h0, "pending_after_claim");
`else
        do_read(5'd16, 32'h8000_0001, "id_ch1_no_side_effect");
        do_read(5'd0, 32'h02, "pending_after_id_read");
`endif

        // Timer passthrough.
        chk("timer_idle", 32'(int_o[5]), 32'd0);
        timer_int_i = 1'b1;
        cycle();
        chk("timer_set", 32'(int_o[5]), 32'd1);
        timer_int_i = 1'b0;
        cycle();
        chk("timer_clear", 32'(int_o[5]), 32'd0);

        // Asynchronous reset mid-operation.
        do_write(5'd0, 32'hFF);
        pulse(8'h02);
        wait_cycles(4);
        chk("pre_reset_int", 32'(int_o[1]), 32'd1);
        rst = 1'b1;
        #2;
        chk("async_reset_int", 32'(int_o), 32'd0);
        chk("async_reset_rdata", rdata_o, 32'd0);
        cycle();
        rst = 1'b0;
        do_read(5'd0, 32'h0, "post_reset_pending");
        do_read(5'd4, 32'h0, "post_reset_mask");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Parametrised external interrupt controller. It sits between the SoC interrupt sources and the CPU core's 6-bit CP0 interrupt input.
- Generalises the single-line int_i/timer_int_o scheme to NUM_IRQ channels.
- Per-channel features: synchroniser, edge/level mode, polarity, mask, sticky pending and priority ID.
- All control state is reached through a simple word-addressed register port driven from the MEM-stage data bus.

Parameters:
NUM_IRQ, 8, number of external interrupt channels (1..32)
SYNC_STAGES, 2, synchroniser flop depth per channel (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
irq_i  in  NUM_IRQ  raw external interrupt requests, asynchronous
timer_int_i  in  1  CP0 timer interrupt
ce_i  in  1  register access enable
we_i  in  1  1=write, 0=read (qualified by ce_i)
addr_i  in  5  byte address; addr_i[4:2] selects register, addr_i[1:0] ignored
wdata_i  in  32  write data
rdata_o  out  32  registered read data
int_o  out  6  to CP0 int_i

Behaviour:
Reset and clocking:
- One clock domain. Reset is asynchronous and active-high.
- On reset: sync flops, edge-history, PENDING, MASK, MODE, POLARITY, int_o and rdata_o all go to 0.
- Reset asserted mid-operation discards all pending state immediately.

Registers (word index = addr_i[4:2]):
- 0 PENDING: read, or write-1-to-clear.
- 1 MASK: read/write, 1 = enabled.
- 2 MODE: read/write, 1 = edge, 0 = level.
- 3 POLARITY: read/write, 1 = active-low.
- 4 ID: read-only. bit31 = valid; bits[4:0] = index of the lowest-numbered channel with PENDING&MASK set. 0 when none.
- Index 5..7: read 0, writes ignored.
- Bits at and above NUM_IRQ: read 0, writes ignored.

Register access timing:
- A write takes effect at the clock edge on which ce_i&we_i is sampled.
- A read (ce_i&~we_i) loads rdata_o at that edge, giving 1-cycle read latency.
- rdata_o holds its value until the next read.
- A read reflects register state from before the same edge.

Per-channel input path:
- s[i] = irq_i[i] after SYNC_STAGES flops, then XOR POLARITY[i].
- h[i] = s[i] registered each cycle (edge history).

PENDING update each cycle:
- Level mode: PENDING[i] <= s[i]. W1C has no effect.
- Edge mode: PENDING[i] <= 1 if s[i]&~h[i]; else cleared if W1C bit set; else hold.
- Edge mode, simultaneous rising edge and W1C on the same cycle: set wins.

Mode and polarity changes:
- Edge→level: PENDING follows s[i] from the next cycle.
- Level→edge: PENDING holds its current value until cleared.
- A POLARITY write can flip s[i] and create one edge event. Software clears it.

Outputs:
- int_o[k] (k=0..4) is registered, = OR over channels i with i mod 5 == k of PENDING[i]&MASK[i].
- int_o[5] = timer_int_i, registered.
- Latency irq_i edge → int_o = SYNC_STAGES+2 clocks. Default: 4.
- MASK change → int_o: 1 clock.

Optional Feature:
INT_CTRL_CLAIM_EN
- Defined: a read of ID with valid=1 clears PENDING of the reported channel at the same edge, if that channel is in edge mode. A rising edge detected on that same cycle wins over the clear. Level-mode channels are unaffected.
- Undefined: ID reads have no side effects.

Test Plan:
- Reset, then read all 5 registers → every rdata_o = 0x00000000 and int_o = 6'b0.
- MASK=0xFF, MODE=0x01; pulse irq_i[0] high 1 clk → PENDING=0x01 and int_o[0]=1 exactly 4 clks after the pulse. W1C 0x01 → int_o[0]=0 one clk later.
- Level channel 6 (MODE[6]=0) held high → int_o[1]=1. W1C 0x40 ignored (PENDING[6] stays 1). Drop irq_i[6] → int_o[1]=0 after 4 clks.
- Channels 3 and 5 pending, both masked in → ID reads 0x80000003. MASK=0xF7 → ID reads 0x80000005. MASK=0 → ID reads 0, int_o=0.
- POLARITY[2]=1, MODE[2]=1, irq_i[2] idle high, then a falling edge → PENDING[2] set. Edge arriving on the same cycle as a W1C of bit 2 → PENDING[2] remains 1.
- INT_CTRL_CLAIM_EN defined, edge channel 1 pending → first ID read returns 0x80000001, second ID read returns 0x00000000. timer_int_i=1 → int_o[5]=1 next clk in all configurations.
